// File: rtl/press_scheduler.sv
// Two-player key sequencer: release detect, one-deep per-player queue, one-at-a-time grants with cooldown.
// Build option PRESS_SCHED_RR_EN: round-robin tie-break against last_grant (default: left wins ties).
module press_scheduler #(
    parameter int COOLDOWN = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             key_l,
    input  logic             key_r,
    output logic             move_l,
    output logic             move_r,
    output logic             busy,
    output logic             last_grant,
    output logic [CNT_W-1:0] dropped
);

    // state | meaning
    // IDLE  | waiting for a pending event while en is high
    // GRANT | one-cycle move pulse for the latched winner (sel)
    // COOL  | lockout, COOLDOWN cycles, before the next grant may be considered
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        COOL  = 2'd2
    } state_t;

    localparam int CNT_CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CNT_CW-1:0] CNT_LAST = CNT_CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_kprev_l;
    logic              r_kprev_r;
    logic              r_pend_l;
    logic              r_pend_r;
    logic              r_sel;
    logic              w_sel_nxt;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_dropped;
    logic [CNT_CW-1:0] r_cnt;
    logic [CNT_CW-1:0] w_cnt_nxt;

    logic              w_e_l;
    logic              w_e_r;
    logic              w_clr_l;
    logic              w_clr_r;
    logic              w_drop_l;
    logic              w_drop_r;
    logic              w_tie_sel;
    logic              w_winner;
    logic [CNT_W:0]    w_drop_sum;

    assign w_e_l = r_kprev_l & ~key_l;
    assign w_e_r = r_kprev_r & ~key_r;

`ifdef PRESS_SCHED_RR_EN
    assign w_tie_sel = ~r_last_grant;
`else
    assign w_tie_sel = 1'b0;
`endif

    assign w_winner = (r_pend_l & r_pend_r) ? w_tie_sel : r_pend_r;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_clr_l     = 1'b0;
        w_clr_r     = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && (r_pend_l || r_pend_r)) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_winner;
                end
            end
            GRANT: begin
                w_clr_l     = ~r_sel;
                w_clr_r     = r_sel;
                w_cnt_nxt   = '0;
                w_state_nxt = (COOLDOWN == 0) ? IDLE : COOL;
            end
            COOL: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // An event landing on the edge its own flag is granted re-arms the flag rather than counting as a drop.
    assign w_drop_l   = en & w_e_l & r_pend_l & ~w_clr_l;
    assign w_drop_r   = en & w_e_r & r_pend_r & ~w_clr_r;
    assign w_drop_sum = {1'b0, r_dropped} + (CNT_W + 1)'(w_drop_l) + (CNT_W + 1)'(w_drop_r);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_kprev_l    <= 1'b0;
            r_kprev_r    <= 1'b0;
            r_pend_l     <= 1'b0;
            r_pend_r     <= 1'b0;
            r_sel        <= 1'b0;
            r_last_grant <= 1'b1;
            r_dropped    <= '0;
            r_cnt        <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_kprev_l <= key_l;
            r_kprev_r <= key_r;
            r_sel     <= w_sel_nxt;
            r_cnt     <= w_cnt_nxt;
            if (en) begin
                r_pend_l <= w_e_l | (r_pend_l & ~w_clr_l);
                r_pend_r <= w_e_r | (r_pend_r & ~w_clr_r);
            end else begin
                r_pend_l <= 1'b0;
                r_pend_r <= 1'b0;
            end
            if (r_state == GRANT) begin
                r_last_grant <= r_sel;
            end
            r_dropped <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
        end
    end

    assign move_l     = (r_state == GRANT) & ~r_sel;
    assign move_r     = (r_state == GRANT) & r_sel;
    assign busy       = (r_state != IDLE);
    assign last_grant = r_last_grant;
    assign dropped    = r_dropped;

endmodule
